// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared constants and types for recovering BCD digits from a multiplexed
// seven-segment bus. Segment order is {a,b,c,d,e,f,g}, bit 6 = a, active-high.
package seven_seg_pkg;

   localparam logic [6:0] BLANK = 7'b0000000;
   localparam logic [6:0] ZERO  = 7'b1111110;
   localparam logic [6:0] ONE   = 7'b0110000;
   localparam logic [6:0] TWO   = 7'b1101101;
   localparam logic [6:0] THREE = 7'b1111001;
   localparam logic [6:0] FOUR  = 7'b0110011;
   localparam logic [6:0] FIVE  = 7'b1011011;
   localparam logic [6:0] SIX   = 7'b0011111;
   localparam logic [6:0] SEVEN = 7'b1110000;
   localparam logic [6:0] EIGHT = 7'b1111111;
   localparam logic [6:0] NINE  = 7'b1111011;

   localparam logic [3:0] SLOT_BLANK = 4'hF;
   localparam logic [3:0] SLOT_ERR   = 4'hE;

   // Per-dwell tracking: IDLE while the strobe is not one-hot, SETTLE while
   // counting identical samples, HELD once this dwell has been captured.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } scan_state_e;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Display-bus bundle between a scanned seven-segment source and the decoder.
// Names carry the decoder's view: i_ are driven into it, o_ come out of it.
interface seven_seg_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);

   logic [6:0]              i_display;
   logic [NUM_DIGITS-1:0]   i_digit_sel;
   logic [4*NUM_DIGITS-1:0] o_bcd_out;
   logic [NUM_DIGITS-1:0]   o_blank_mask;
   logic                    o_error;
   logic                    o_frame_valid;

   modport master (
      output i_display,
      output i_digit_sel,
      input  o_bcd_out,
      input  o_blank_mask,
      input  o_error,
      input  o_frame_valid
   );

   modport slave (
      input  i_display,
      input  i_digit_sel,
      output o_bcd_out,
      output o_blank_mask,
      output o_error,
      output o_frame_valid
   );

endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Combinational inverse of the BCD-to-segment decoder: maps one 7-bit pattern
// to its digit, flagging blanks and anything outside the recognised set.
module seven_seg_pattern_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] i_pattern,
   output logic [3:0] o_bcd,
   output logic       o_valid,
   output logic       o_blank
);

   // Pattern lookup; unknown patterns report SLOT_ERR with neither flag set
   always_comb begin
      o_bcd   = SLOT_ERR;
      o_valid = 1'b0;
      o_blank = 1'b0;
      case (i_pattern)
         ZERO:    begin o_bcd = 4'd0; o_valid = 1'b1; end
         ONE:     begin o_bcd = 4'd1; o_valid = 1'b1; end
         TWO:     begin o_bcd = 4'd2; o_valid = 1'b1; end
         THREE:   begin o_bcd = 4'd3; o_valid = 1'b1; end
         FOUR:    begin o_bcd = 4'd4; o_valid = 1'b1; end
         FIVE:    begin o_bcd = 4'd5; o_valid = 1'b1; end
         SIX:     begin o_bcd = 4'd6; o_valid = 1'b1; end
         SEVEN:   begin o_bcd = 4'd7; o_valid = 1'b1; end
         EIGHT:   begin o_bcd = 4'd8; o_valid = 1'b1; end
         NINE:    begin o_bcd = 4'd9; o_valid = 1'b1; end
         BLANK:   begin o_bcd = SLOT_BLANK; o_blank = 1'b1; end
         default: begin o_bcd = SLOT_ERR; o_valid = 1'b0; o_blank = 1'b0; end
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Watches a time-multiplexed seven-segment bus, filters each digit dwell for
// stability and rebuilds a frame of BCD digits with a one-cycle valid pulse.
module seven_seg_scan_decoder
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int STABLE_CNT = 3
)(
   input  logic                     clk,
   input  logic                     rst,
   seven_seg_scan_decoder_if.slave  bus
);

   localparam int              SAMPLE_W = NUM_DIGITS + 7;
   localparam int              CNT_W    = $clog2(STABLE_CNT);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CNT - 1);

   logic [SAMPLE_W-1:0]     w_sample;
   logic [SAMPLE_W-1:0]     r_sample;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cnt_nxt;
   scan_state_e             r_state;
   logic                    w_sel_onehot;
   logic                    w_same;
   logic                    w_capture;
   logic [NUM_DIGITS-1:0]   w_cap_sel;
   logic [NUM_DIGITS-1:0]   w_mask_nxt;
   logic                    w_frame_done;

   logic [3:0]              w_dec_bcd;
   logic                    w_dec_valid;
   logic                    w_dec_blank;
   logic                    w_dec_err;

   logic [4*NUM_DIGITS-1:0] r_bcd;
   logic [NUM_DIGITS-1:0]   r_blank;
   logic [NUM_DIGITS-1:0]   r_mask;
   logic                    r_err;
   logic                    r_fv;

   assign w_sample  = {bus.i_digit_sel, bus.i_display};
   assign w_cap_sel = r_sample[SAMPLE_W-1:7];

   // At a capture edge the incoming sample equals r_sample, so decoding the
   // registered copy keeps the input pins out of the decode path.
   seven_seg_pattern_decode u_decode (
      .i_pattern (r_sample[6:0]),
      .o_bcd     (w_dec_bcd),
      .o_valid   (w_dec_valid),
      .o_blank   (w_dec_blank)
   );

   assign w_dec_err    = !w_dec_valid && !w_dec_blank;
   assign w_mask_nxt   = r_mask | w_cap_sel;
   assign w_frame_done = w_capture && (&w_mask_nxt);

   // Stability count and the single capture strobe of each dwell
   always_comb begin
      w_sel_onehot = $onehot(bus.i_digit_sel);
      w_same       = (w_sample == r_sample);
      w_cnt_nxt    = '0;
      w_capture    = 1'b0;
      if (w_sel_onehot && w_same) begin
         if (r_cnt == CNT_TOP) begin
            w_cnt_nxt = CNT_TOP;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end else begin
         w_cnt_nxt = '0;
      end
      if ((w_cnt_nxt == CNT_TOP) && (r_state != ST_HELD)) begin
         w_capture = 1'b1;
      end else begin
         w_capture = 1'b0;
      end
   end

   // Sample register, counter and per-dwell state machine
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample <= '0;
         r_cnt    <= '0;
         r_state  <= ST_IDLE;
      end else begin
         r_sample <= w_sample;
         r_cnt    <= w_cnt_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_sel_onehot) r_state <= ST_SETTLE;
               else              r_state <= ST_IDLE;
            end
            ST_SETTLE: begin
               if (!w_sel_onehot)  r_state <= ST_IDLE;
               else if (w_capture) r_state <= ST_HELD;
               else                r_state <= ST_SETTLE;
            end
            ST_HELD: begin
               if (!w_sel_onehot) r_state <= ST_IDLE;
               else if (!w_same)  r_state <= ST_SETTLE;
               else               r_state <= ST_HELD;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Slot registers, frame bookkeeping and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bcd   <= {NUM_DIGITS{SLOT_BLANK}};
         r_blank <= '1;
         r_mask  <= '0;
         r_err   <= 1'b0;
         r_fv    <= 1'b0;
      end else begin
         r_fv <= w_frame_done;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_capture && w_cap_sel[k]) begin
               r_bcd[4*k +: 4] <= w_dec_bcd;
               r_blank[k]      <= w_dec_blank;
            end
         end
         if (w_frame_done) begin
            // A completing capture starts a fresh frame; only its own error carries over.
            r_mask <= '0;
            r_err  <= w_dec_err;
         end else if (w_capture) begin
            r_mask <= w_mask_nxt;
            r_err  <= r_err | w_dec_err;
         end else begin
            r_mask <= r_mask;
            r_err  <= r_err;
         end
      end
   end

   assign bus.o_bcd_out     = r_bcd;
   assign bus.o_blank_mask  = r_blank;
   assign bus.o_error       = r_err;
   assign bus.o_frame_valid = r_fv;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed dwell table, a latency sequence
// and randomized scans, all checked against a run-length reference model.
module tb_seven_seg_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seven_seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

   seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit         rst_before;
      logic [3:0] sel;
      logic [6:0] disp;
      int         cycles;
      logic [15:0] exp_bcd;
      logic [3:0] exp_blank;
      logic       exp_err;
      int         exp_fv_at;
   } vec_t;

   vec_t       vecs[$];
   logic [6:0] pat [10];
   int         checks = 0;
   int         errors = 0;

   // Reference model state: length of the current identical one-hot run
   logic [10:0] m_prev;
   bit          m_have_prev;
   int          m_run;
   logic [3:0]  m_slot [ND];
   logic [3:0]  m_blank;
   logic [3:0]  m_mask;
   logic        m_err;
   logic        m_fv;

   task automatic model_reset();
      m_have_prev = 1'b0;
      m_run       = 0;
      for (int i = 0; i < ND; i++) m_slot[i] = 4'hF;
      m_blank = 4'hF;
      m_mask  = 4'h0;
      m_err   = 1'b0;
      m_fv    = 1'b0;
   endtask

   // A dwell is captured exactly when its SC-th identical sample arrives
   task automatic model_update(input logic [3:0] sel, input logic [6:0] disp);
      int         k;
      logic [3:0] code;
      bit         bad;
      bit         blank;
      if ($countones(sel) != 1) m_run = 0;
      else if (m_have_prev && ({sel, disp} == m_prev)) m_run++;
      else m_run = 1;
      m_prev      = {sel, disp};
      m_have_prev = 1'b1;
      m_fv        = 1'b0;
      if (m_run == SC) begin
         k = 0;
         for (int i = 0; i < ND; i++) if (sel[i]) k = i;
         code = 4'hE; bad = 1'b1; blank = 1'b0;
         if (disp == 7'b0000000) begin code = 4'hF; bad = 1'b0; blank = 1'b1; end
         for (int d = 0; d < 10; d++) begin
            if (pat[d] == disp) begin code = d[3:0]; bad = 1'b0; end
         end
         m_slot[k]  = code;
         m_blank[k] = blank;
         m_mask[k]  = 1'b1;
         if (m_mask == 4'hF) begin
            m_fv   = 1'b1;
            m_mask = 4'h0;
            m_err  = bad;
         end else begin
            m_err = m_err | bad;
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [15:0] exp_bcd;
      exp_bcd = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
      checks++;
      if (bus.o_bcd_out !== exp_bcd || bus.o_blank_mask !== m_blank ||
          bus.o_error !== m_err || bus.o_frame_valid !== m_fv) begin
         errors++;
         $display("FAIL %s t=%0t got bcd=%h blank=%b err=%b fv=%b want bcd=%h blank=%b err=%b fv=%b",
                  tag, $time, bus.o_bcd_out, bus.o_blank_mask, bus.o_error, bus.o_frame_valid,
                  exp_bcd, m_blank, m_err, m_fv);
      end
   endtask

   task automatic step(input logic [3:0] sel, input logic [6:0] disp, input string tag);
      bus.i_digit_sel = sel;
      bus.i_display   = disp;
      @(posedge clk);
      #1;
      model_update(sel, disp);
      check_model(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      model_reset();
      checks++;
      if (bus.o_bcd_out !== 16'hFFFF || bus.o_blank_mask !== 4'hF ||
          bus.o_error !== 1'b0 || bus.o_frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_values got bcd=%h blank=%b err=%b fv=%b want bcd=ffff blank=1111 err=0 fv=0",
                  bus.o_bcd_out, bus.o_blank_mask, bus.o_error, bus.o_frame_valid);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic add(input bit r, input logic [3:0] s, input logic [6:0] d, input int c,
                      input logic [15:0] eb, input logic [3:0] ebl, input logic ee, input int ef);
      vec_t v;
      v.rst_before = r; v.sel = s; v.disp = d; v.cycles = c;
      v.exp_bcd = eb; v.exp_blank = ebl; v.exp_err = ee; v.exp_fv_at = ef;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          fv_at;
      logic [3:0]  rsel;
      logic [6:0]  rdisp;
      int          rsel_kind;
      int          rdisp_kind;

      pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101; pat[3] = 7'b1111001;
      pat[4] = 7'b0110011; pat[5] = 7'b1011011; pat[6] = 7'b0011111; pat[7] = 7'b1110000;
      pat[8] = 7'b1111111; pat[9] = 7'b1111011;

      // Scan 1,2,3,4 on digits 0..3
      add(0, 4'b0001, pat[1], 5, 16'hFFF1, 4'b1110, 1'b0, -1);
      add(0, 4'b0010, pat[2], 5, 16'hFF21, 4'b1100, 1'b0, -1);
      add(0, 4'b0100, pat[3], 5, 16'hF321, 4'b1000, 1'b0, -1);
      add(0, 4'b1000, pat[4], 5, 16'h4321, 4'b0000, 1'b0,  2);
      // Short dwell on digit 2 is ignored
      add(0, 4'b0001, pat[5], 5, 16'h4325, 4'b0000, 1'b0, -1);
      add(0, 4'b0010, pat[6], 5, 16'h4365, 4'b0000, 1'b0, -1);
      add(0, 4'b0100, pat[7], 2, 16'h4365, 4'b0000, 1'b0, -1);
      add(0, 4'b1000, pat[8], 5, 16'h8365, 4'b0000, 1'b0, -1);
      add(0, 4'b0100, pat[7], 3, 16'h8765, 4'b0000, 1'b0,  2);
      // Blank digit 1
      add(0, 4'b0001, pat[0], 5, 16'h8760, 4'b0000, 1'b0, -1);
      add(0, 4'b0010, 7'b0000000, 5, 16'h87F0, 4'b0010, 1'b0, -1);
      add(0, 4'b0100, pat[9], 5, 16'h89F0, 4'b0010, 1'b0, -1);
      add(0, 4'b1000, pat[3], 5, 16'h39F0, 4'b0010, 1'b0,  2);
      // Invalid digit 0 completes a frame, then a clean frame clears Error
      add(0, 4'b0010, pat[1], 5, 16'h3910, 4'b0000, 1'b0, -1);
      add(0, 4'b0100, pat[2], 5, 16'h3210, 4'b0000, 1'b0, -1);
      add(0, 4'b1000, pat[4], 5, 16'h4210, 4'b0000, 1'b0, -1);
      add(0, 4'b0001, 7'b1010101, 5, 16'h421E, 4'b0000, 1'b1,  2);
      add(0, 4'b0001, pat[5], 5, 16'h4215, 4'b0000, 1'b1, -1);
      add(0, 4'b0010, pat[6], 5, 16'h4265, 4'b0000, 1'b1, -1);
      add(0, 4'b0100, pat[7], 5, 16'h4765, 4'b0000, 1'b1, -1);
      add(0, 4'b1000, pat[8], 5, 16'h8765, 4'b0000, 1'b0,  2);
      // Multi-hot select never captures
      add(0, 4'b0110, pat[8], 10, 16'h8765, 4'b0000, 1'b0, -1);
      add(0, 4'b0001, pat[9], 3, 16'h8769, 4'b0000, 1'b0, -1);
      // Reset after digits 0..2 captured discards the partial frame
      add(0, 4'b0010, pat[2], 5, 16'h8729, 4'b0000, 1'b0, -1);
      add(0, 4'b0100, pat[3], 5, 16'h8329, 4'b0000, 1'b0, -1);
      add(1, 4'b1000, pat[4], 5, 16'h4FFF, 4'b0111, 1'b0, -1);
      add(0, 4'b0001, pat[1], 5, 16'h4FF1, 4'b0110, 1'b0, -1);
      add(0, 4'b0010, pat[2], 5, 16'h4F21, 4'b0100, 1'b0, -1);
      add(0, 4'b0100, pat[3], 5, 16'h4321, 4'b0000, 1'b0,  2);

      bus.i_digit_sel = 4'b0000;
      bus.i_display   = 7'b0000000;
      rst = 1'b0;
      #1;
      do_reset();

      foreach (vecs[i]) begin
         if (vecs[i].rst_before) do_reset();
         fv_at = -1;
         for (int c = 0; c < vecs[i].cycles; c++) begin
            step(vecs[i].sel, vecs[i].disp, "model_directed");
            if (bus.o_frame_valid === 1'b1 && fv_at < 0) fv_at = c;
         end
         checks++;
         if (bus.o_bcd_out !== vecs[i].exp_bcd || bus.o_blank_mask !== vecs[i].exp_blank ||
             bus.o_error !== vecs[i].exp_err || fv_at != vecs[i].exp_fv_at) begin
            errors++;
            $display("FAIL vec%0d got bcd=%h blank=%b err=%b fv_at=%0d want bcd=%h blank=%b err=%b fv_at=%0d",
                     i, bus.o_bcd_out, bus.o_blank_mask, bus.o_error, fv_at,
                     vecs[i].exp_bcd, vecs[i].exp_blank, vecs[i].exp_err, vecs[i].exp_fv_at);
         end
      end

      // Capture latency: slot changes on the third identical sample, not before
      do_reset();
      step(4'b0100, pat[7], "lat_s0");
      step(4'b0100, pat[7], "lat_s1");
      checks++;
      if (bus.o_bcd_out !== 16'hFFFF) begin
         errors++;
         $display("FAIL latency_early got bcd=%h want bcd=ffff", bus.o_bcd_out);
      end
      step(4'b0100, pat[7], "lat_s2");
      checks++;
      if (bus.o_bcd_out !== 16'hF7FF || bus.o_blank_mask !== 4'b1011) begin
         errors++;
         $display("FAIL latency_capture got bcd=%h blank=%b want bcd=f7ff blank=1011",
                  bus.o_bcd_out, bus.o_blank_mask);
      end

      // Randomized scans against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) < 3) do_reset();
         rsel_kind = $urandom_range(0, 99);
         if (rsel_kind < 85) rsel = 4'b0001 << $urandom_range(0, 3);
         else                rsel = 4'($urandom_range(0, 15));
         rdisp_kind = $urandom_range(0, 99);
         if (rdisp_kind < 70)      rdisp = pat[$urandom_range(0, 9)];
         else if (rdisp_kind < 85) rdisp = 7'b0000000;
         else                      rdisp = 7'($urandom_range(0, 127));
         for (int c = 0; c < int'($urandom_range(1, 6)); c++) begin
            step(rsel, rdisp, "model_random");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Recovers BCD digits from a time-multiplexed seven-segment display bus. This is the inverse of the BCD-to-segment display decoder. The block watches the segment lines plus a one-hot digit-select strobe, applies a stability filter to each digit dwell, and decodes each stable pattern back to BCD. It publishes a full frame of digits with a one-cycle valid pulse. It sits on the readback and self-check path beside the display driver, and also serves as a monitor for external display buses.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (≥1)
- STABLE_CNT, 3, consecutive identical samples required before capture (≥2)
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- Display  input  7  segment lines {a,b,c,d,e,f,g}, bit 6 = a, active-high
- Digit_Sel  input  NUM_DIGITS  one-hot digit strobe, bit k = digit k
- BCD_Out  output  4*NUM_DIGITS  decoded digits, digit k at [4k+3:4k]
- Blank_Mask  output  NUM_DIGITS  bit k set if digit k was blank in the last capture
- Error  output  1  sticky: an unrecognised pattern was captured in the current frame
- Frame_Valid  output  1  one-cycle pulse: all digits captured since the previous pulse

## Operation
- Pattern set (abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=0011111, 7=1110000, 8=1111111, 9=1111011, blank=0000000.
- Sample register: {Digit_Sel, Display} is registered every cycle.
- Stability counter:
  - Increments (saturating at STABLE_CNT-1) while the current sample equals the previous sample and Digit_Sel is one-hot.
  - Otherwise it loads 0.
  - A zero or multi-hot Digit_Sel also clears the dwell-captured flag.
- Capture: when the counter reaches STABLE_CNT-1 and the dwell-captured flag is clear:
  - Decode Display and write slot k (k = index of the Digit_Sel bit).
  - Set captured_mask[k] and set the dwell-captured flag.
  - Only one capture happens per dwell. The flag clears on any sample change.
- Decode results:
  - Valid digit: slot = 0–9, Blank_Mask[k] = 0.
  - Blank: slot = 4'hF, Blank_Mask[k] = 1.
  - Unrecognised pattern: slot = 4'hE, Blank_Mask[k] = 0, Error set.
- Frame completion:
  - When a capture makes captured_mask all-ones, Frame_Valid pulses.
  - On the same edge, captured_mask loads 0 (that capture is not carried into the next frame).
  - Error clears at that edge unless the completing capture itself is invalid, in which case Error stays 1 into the new frame.
- Recapturing a digit already in captured_mask overwrites its slot. It does not generate an extra frame.
- FSM per dwell: IDLE (sel invalid) → SETTLE (counting) → HELD (captured, waiting for change) → SETTLE on pattern/select change, or IDLE on invalid select.

## Timing
- Reset values: BCD_Out all 4'hF, Blank_Mask all 1, Error 0, Frame_Valid 0, captured_mask 0, counter 0, state IDLE.
- Reset asserted mid-dwell discards the partial frame. After deassertion, sampling starts on the next rising edge.
- Latency: if a stable input is first present at edge t, the slot update is visible after edge t+STABLE_CNT-1.
- Frame_Valid is high in the same cycle the completing slot becomes visible, for exactly one cycle.
- A dwell shorter than STABLE_CNT samples is never captured.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package seven_seg_pkg holds:
  - segment pattern constants (BLANK, ZERO…NINE)
  - slot codes SLOT_BLANK = 4'hF and SLOT_ERR = 4'hE
  - an FSM state typedef
- Sub-module seven_seg_pattern_decode: purely combinational, 7-bit pattern → {bcd[3:0], valid, blank}. It is reusable by the display driver's checker.
- Top level holds the sample register, counter, FSM, slot registers, captured_mask and sticky Error.

## Test plan
- Reset, then scan digits 0..3 showing 1,2,3,4, each held 5 cycles → BCD_Out = 16'h4321, Blank_Mask = 0, Frame_Valid pulses once, 2 cycles after digit 3's dwell begins.
- Digit 2 dwell of only 2 cycles (STABLE_CNT = 3) → slot 2 unchanged, no Frame_Valid until a ≥3-cycle dwell on digit 2.
- Digit 1 = 0000000 during a full scan → slot 1 = 4'hF, Blank_Mask = 4'b0010, Error = 0.
- Digit 0 = 1010101 → slot 0 = 4'hE, Error = 1 through the Frame_Valid pulse. Error clears after the next clean frame.
- Digit_Sel = 4'b0110 for 10 cycles → no capture. A following valid dwell needs the full STABLE_CNT samples.
- rst pulsed after digits 0–2 are captured → outputs return to reset values. A full 4-digit scan is required for the next Frame_Valid.
